// File: rtl/dice_pkg.sv
// Shared definitions for the two-player dice turn controller: state codes,
// face width, winner codes and the raw-RNG-to-face mapping.
package dice_pkg;

   localparam int FACE_W = 3;

   typedef logic [2:0] state_t;

   localparam state_t ST_IDLE   = 3'd0;
   localparam state_t ST_WAIT1  = 3'd1;
   localparam state_t ST_ROLL1  = 3'd2;
   localparam state_t ST_LATCH1 = 3'd3;
   localparam state_t ST_WAIT2  = 3'd4;
   localparam state_t ST_ROLL2  = 3'd5;
   localparam state_t ST_LATCH2 = 3'd6;
   localparam state_t ST_DONE   = 3'd7;

   localparam logic [1:0] WIN_NONE = 2'b00;
   localparam logic [1:0] WIN_P1   = 2'b01;
   localparam logic [1:0] WIN_P2   = 2'b10;

   // The 3-bit RNG covers 0..7; 6 and 7 fold back onto faces 1 and 2.
   function automatic logic [FACE_W-1:0] rand_to_face(input logic [FACE_W-1:0] r);
      logic [FACE_W-1:0] folded;
      folded = (r >= 3'd6) ? (r - 3'd6) : r;
      return folded + 3'd1;
   endfunction

endpackage

// File: rtl/key_edge_sync.sv
// Two-flop synchronizer for a raw push-button level followed by a
// rising-edge detector; pulse is high for one clk per press.
module key_edge_sync (
   input  logic clk,
   input  logic reset,
   input  logic key,
   output logic pulse
);

   logic meta;
   logic sync;
   logic prev;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         meta <= 1'b0;
         sync <= 1'b0;
         prev <= 1'b0;
      end else begin
         meta <= key;
         sync <= meta;
         prev <= sync;
      end
   end

   assign pulse = sync & ~prev;

endmodule

// File: rtl/dice_turn_ctrl.sv
// Two-player dice game sequencer: alternating turns, timed RNG runs,
// face latching, saturating score accumulation and winner detection.
// Optional build macro DICE_EXTRA_TURN_EN: a non-winning 6 grants the same
// player another roll instead of passing the turn.
//
// state  | meaning
// IDLE   | after reset, waiting for the first start
// WAIT1  | player 1 to roll, waiting for req1
// ROLL1  | player 1 RNG running, counter timing the roll
// LATCH1 | capture player 1 face, update score, decide next turn
// WAIT2  | player 2 to roll, waiting for req2
// ROLL2  | player 2 RNG running
// LATCH2 | capture player 2 face, update score, decide next turn
// DONE   | target reached, results held until start
module dice_turn_ctrl
   import dice_pkg::*;
#(
   parameter int TARGET_SCORE = 100,
   parameter int ROLL_CYCLES  = 32,
   parameter int SCORE_W      = 8
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               start,
   input  logic               req1,
   input  logic               req2,
   input  logic [FACE_W-1:0]  rand1,
   input  logic [FACE_W-1:0]  rand2,
   output logic               rng_run1,
   output logic               rng_run2,
   output logic [FACE_W-1:0]  face1,
   output logic [FACE_W-1:0]  face2,
   output logic [SCORE_W-1:0] score1,
   output logic [SCORE_W-1:0] score2,
   output logic               turn,
   output logic               roll_done,
   output logic               end_of_game,
   output logic [1:0]         winner
);

   localparam int CNT_W = (ROLL_CYCLES > 1) ? $clog2(ROLL_CYCLES) : 1;
   localparam logic [CNT_W-1:0]   CNT_LOAD   = CNT_W'(ROLL_CYCLES - 1);
   localparam logic [SCORE_W:0]   TARGET_EXT = (SCORE_W+1)'(TARGET_SCORE);

   logic start_ev;
   logic req1_ev;
   logic req2_ev;

   state_t           state;
   state_t           state_nxt;
   logic [CNT_W-1:0] cnt;
   logic [CNT_W-1:0] cnt_nxt;

   logic [FACE_W-1:0]  rand_sel;
   logic [FACE_W-1:0]  face_new;
   logic [SCORE_W-1:0] score_cur;
   logic [SCORE_W:0]   score_sum;
   logic [SCORE_W-1:0] score_new;
   logic               hit;
   logic               extra;
   logic               clear;

   key_edge_sync u_sync_start (.clk(clk), .reset(reset), .key(start), .pulse(start_ev));
   key_edge_sync u_sync_req1  (.clk(clk), .reset(reset), .key(req1),  .pulse(req1_ev));
   key_edge_sync u_sync_req2  (.clk(clk), .reset(reset), .key(req2),  .pulse(req2_ev));

   assign rand_sel  = (state == ST_LATCH2) ? rand2 : rand1;
   assign score_cur = (state == ST_LATCH2) ? score2 : score1;
   assign face_new  = rand_to_face(rand_sel);
   assign score_sum = {1'b0, score_cur} + {{(SCORE_W+1-FACE_W){1'b0}}, face_new};
   assign score_new = score_sum[SCORE_W] ? {SCORE_W{1'b1}} : score_sum[SCORE_W-1:0];
   assign hit       = ({1'b0, score_new} >= TARGET_EXT);
   assign clear     = start_ev && ((state == ST_IDLE) || (state == ST_DONE));

`ifdef DICE_EXTRA_TURN_EN
   assign extra = (face_new == 3'd6);
`else
   assign extra = 1'b0;
`endif

   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      case (state)
         ST_IDLE:   if (start_ev) state_nxt = ST_WAIT1;
         ST_WAIT1:  if (req1_ev) begin
                       state_nxt = ST_ROLL1;
                       cnt_nxt   = CNT_LOAD;
                    end
         ST_ROLL1:  if (cnt == '0) state_nxt = ST_LATCH1;
                    else           cnt_nxt   = cnt - CNT_W'(1);
         ST_LATCH1: state_nxt = hit ? ST_DONE : (extra ? ST_WAIT1 : ST_WAIT2);
         ST_WAIT2:  if (req2_ev) begin
                       state_nxt = ST_ROLL2;
                       cnt_nxt   = CNT_LOAD;
                    end
         ST_ROLL2:  if (cnt == '0) state_nxt = ST_LATCH2;
                    else           cnt_nxt   = cnt - CNT_W'(1);
         ST_LATCH2: state_nxt = hit ? ST_DONE : (extra ? ST_WAIT2 : ST_WAIT1);
         ST_DONE:   if (start_ev) state_nxt = ST_WAIT1;
         default:   state_nxt = ST_IDLE;
      endcase
   end

   // Results land on the edge leaving LATCHn, together with roll_done.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state       <= ST_IDLE;
         cnt         <= '0;
         rng_run1    <= 1'b0;
         rng_run2    <= 1'b0;
         face1       <= '0;
         face2       <= '0;
         score1      <= '0;
         score2      <= '0;
         turn        <= 1'b0;
         roll_done   <= 1'b0;
         end_of_game <= 1'b0;
         winner      <= WIN_NONE;
      end else begin
         state       <= state_nxt;
         cnt         <= cnt_nxt;
         rng_run1    <= (state_nxt == ST_ROLL1);
         rng_run2    <= (state_nxt == ST_ROLL2);
         end_of_game <= (state_nxt == ST_DONE);
         roll_done   <= (state == ST_LATCH1) || (state == ST_LATCH2);
         if (clear) begin
            face1  <= '0;
            face2  <= '0;
            score1 <= '0;
            score2 <= '0;
            turn   <= 1'b0;
            winner <= WIN_NONE;
         end
         if (state == ST_LATCH1) begin
            face1  <= face_new;
            score1 <= score_new;
            if (hit)         winner <= WIN_P1;
            else if (!extra) turn   <= 1'b1;
         end
         if (state == ST_LATCH2) begin
            face2  <= face_new;
            score2 <= score_new;
            if (hit)         winner <= WIN_P2;
            else if (!extra) turn   <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_dice_turn_ctrl.sv
// Directed bench for dice_turn_ctrl built with TARGET_SCORE=10 so a full
// game, the DONE hold, restart and a mid-roll reset fit in a short run.
module tb_dice_turn_ctrl;
   import dice_pkg::*;

   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic       start = 1'b0;
   logic       req1 = 1'b0;
   logic       req2 = 1'b0;
   logic [2:0] rand1 = 3'd0;
   logic [2:0] rand2 = 3'd0;
   logic       rng_run1, rng_run2;
   logic [2:0] face1, face2;
   logic [7:0] score1, score2;
   logic       turn, roll_done, end_of_game;
   logic [1:0] winner;

   int tests = 0;
   int fails = 0;

   dice_turn_ctrl #(.TARGET_SCORE(10), .ROLL_CYCLES(32), .SCORE_W(8)) dut (
      .clk(clk), .reset(reset), .start(start), .req1(req1), .req2(req2),
      .rand1(rand1), .rand2(rand2), .rng_run1(rng_run1), .rng_run2(rng_run2),
      .face1(face1), .face2(face2), .score1(score1), .score2(score2),
      .turn(turn), .roll_done(roll_done), .end_of_game(end_of_game), .winner(winner)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic cyc(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic roll(input int p, input logic [2:0] r, input logic [2:0] exp_face,
                       input logic [7:0] exp_score, input logic exp_turn);
      int  hi;
      logic seen;
      if (p == 1) begin rand1 = r; req1 = 1'b1; end
      else        begin rand2 = r; req2 = 1'b1; end
      seen = 1'b0;
      for (int i = 0; i < 10 && !seen; i++) begin
         @(negedge clk);
         seen = (p == 1) ? rng_run1 : rng_run2;
      end
      chk("run_start", seen, 1);
      req1 = 1'b0;
      req2 = 1'b0;
      hi = 0;
      while (((p == 1) ? rng_run1 : rng_run2) && hi < 100) begin
         hi++;
         @(negedge clk);
      end
      chk("run_len", hi, 32);
      chk("done_before", roll_done, 0);
      @(negedge clk);
      chk("done_pulse", roll_done, 1);
      chk("face", (p == 1) ? face1 : face2, exp_face);
      chk("score", (p == 1) ? score1 : score2, exp_score);
      chk("turn", turn, exp_turn);
      @(negedge clk);
      chk("done_after", roll_done, 0);
   endtask

   initial begin
      cyc(3);
      chk("reset_outs", {rng_run1, rng_run2, face1, face2, turn, roll_done, end_of_game, winner}, 0);
      chk("reset_scores", {score1, score2}, 0);
      chk("reset_state", dut.state, ST_IDLE);
      reset = 1'b1;
      cyc(2);

      start = 1'b1;
      cyc(2);
      chk("start_lat2", dut.state, ST_IDLE);
      cyc(1);
      chk("start_lat3", dut.state, ST_WAIT1);
      start = 1'b0;
      chk("start_outs", {turn, winner, end_of_game, score1, score2}, 0);

      roll(1, 3'd3, 3'd4, 8'd4, 1'b1);
      roll(2, 3'd6, 3'd1, 8'd1, 1'b0);

      req2 = 1'b1;
      cyc(6);
      req2 = 1'b0;
      cyc(4);
      chk("ign_req2_state", dut.state, ST_WAIT1);
      chk("ign_req2_run", rng_run2, 0);

      req2 = 1'b1;
      roll(1, 3'd7, 3'd2, 8'd6, 1'b1);
      chk("both_score2", score2, 8'd1);
      chk("both_face2", face2, 3'd1);

      roll(2, 3'd0, 3'd1, 8'd2, 1'b0);
      roll(1, 3'd5, 3'd6, 8'd12, 1'b0);
      chk("win_eog", end_of_game, 1);
      chk("win_who", winner, WIN_P1);
      chk("win_state", dut.state, ST_DONE);

      req1 = 1'b1;
      req2 = 1'b1;
      cyc(8);
      req1 = 1'b0;
      req2 = 1'b0;
      cyc(4);
      chk("done_hold_scores", {score1, score2}, {8'd12, 8'd2});
      chk("done_hold_faces", {face1, face2}, {3'd6, 3'd1});
      chk("done_hold_flags", {end_of_game, winner, rng_run1, rng_run2}, {1'b1, WIN_P1, 2'b00});

      start = 1'b1;
      cyc(3);
      start = 1'b0;
      chk("restart_state", dut.state, ST_WAIT1);
      chk("restart_outs", {score1, score2, face1, face2, winner, end_of_game, turn}, 0);

`ifdef DICE_EXTRA_TURN_EN
      roll(1, 3'd5, 3'd6, 8'd6, 1'b0);
      chk("extra_state", dut.state, ST_WAIT1);
      roll(1, 3'd0, 3'd1, 8'd7, 1'b1);
`else
      roll(1, 3'd5, 3'd6, 8'd6, 1'b1);
`endif

      rand2 = 3'd2;
      req2 = 1'b1;
      cyc(10);
      chk("mid_roll_run2", rng_run2, 1);
      #2 reset = 1'b0;
      #1;
      chk("abort_run2", rng_run2, 0);
      chk("abort_outs", {rng_run1, face1, face2, turn, roll_done, end_of_game, winner}, 0);
      chk("abort_scores", {score1, score2}, 0);
      chk("abort_state", dut.state, ST_IDLE);
      req2 = 1'b0;
      cyc(2);
      reset = 1'b1;
      cyc(2);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/dice_turn_ctrl.md
Name: dice_turn_ctrl

Overview:
- Game sequencer for the two-player dice game. Sits between the push-button inputs, the two random number generators and the score/VGA datapath.
- Enforces alternating turns (P1, then P2) and runs each roll for a fixed number of cycles.
- Latches each die face, accumulates per-player scores, and declares end of game and the winner when a target score is reached.
- Replaces the free-running per-key score counters with one clocked controller.

Parameters:
- TARGET_SCORE, 100, score at which a player wins (compared with >=)
- ROLL_CYCLES, 32, clock cycles each RNG is kept running per roll (must be >=1)
- SCORE_W, 8, score accumulator width

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous active-low reset
- start  in  1  new-game request, raw active-high level
- req1  in  1  player 1 roll request, raw active-high level
- req2  in  1  player 2 roll request, raw active-high level
- rand1  in  3  player 1 RNG value
- rand2  in  3  player 2 RNG value
- rng_run1  out  1  high while player 1 RNG must advance
- rng_run2  out  1  high while player 2 RNG must advance
- face1  out  3  last latched player 1 face, 1..6; 0 = none yet
- face2  out  3  last latched player 2 face, 1..6; 0 = none yet
- score1  out  SCORE_W  player 1 accumulated score
- score2  out  SCORE_W  player 2 accumulated score
- turn  out  1  0 = player 1 to roll, 1 = player 2 to roll
- roll_done  out  1  one-cycle pulse when a face is latched
- end_of_game  out  1  high in DONE state
- winner  out  2  00 none, 01 P1, 10 P2

Behaviour:
- Reset (asynchronous, active-low): all outputs 0, state IDLE, roll counter 0, synchronizer flops 0.
- Inputs start, req1, req2 each pass through a 2-FF synchronizer plus rising-edge detector. An event is a 1-cycle pulse 3 clk after the raw rising edge. Held levels produce only one event.
- States: IDLE, WAIT1, ROLL1, LATCH1, WAIT2, ROLL2, LATCH2, DONE.
- IDLE: on start event, clear scores, faces and winner; go to WAIT1 with turn=0.
- WAITn: on reqn event, load roll counter with ROLL_CYCLES-1 and go to ROLLn.
  - The other player's request is ignored.
  - If both requests arrive in the same cycle, only the current player's request is served.
- ROLLn: rng_runn=1 (registered; asserted on every ROLLn cycle, 0 elsewhere). Counter decrements each cycle; at 0 go to LATCHn. ROLLn lasts exactly ROLL_CYCLES cycles.
- LATCHn: face = (randn>=6 ? randn-6 : randn) + 1, so 6 maps to 1 and 7 maps to 2.
  - scoren += face, saturating at 2^SCORE_W-1.
  - roll_done=1 for this one cycle.
  - If the new score >= TARGET_SCORE, go to DONE and set winner. Otherwise go to WAIT of the other player and toggle turn.
- Face and score outputs update on the clk edge leaving LATCHn. The roll_done pulse coincides with the new values being visible.
- DONE: end_of_game=1. Scores, faces and winner hold; req events are ignored. A start event behaves as in IDLE (restart).
- A start event in any state other than IDLE or DONE is ignored.
- Reset asserted mid-roll aborts immediately to IDLE; rng_run drops asynchronously.

Optional Feature:
- Macro: DICE_EXTRA_TURN_EN.
- Defined: a latched face of 6 that does not end the game returns to the same player's WAIT state. turn does not toggle.
- Undefined: turns strictly alternate after every roll.

Decomposition:
- Package dice_pkg holds:
  - the state enum, 3-bit encoding;
  - FACE_W=3;
  - WIN_NONE / WIN_P1 / WIN_P2 constants;
  - the rand-to-face mapping function.
- One sub-module, key_edge_sync (2-FF synchronizer + rising-edge pulse), instantiated three times for start, req1 and req2.

Test Plan:
- Reset then start pulse -> 3 cycles later state WAIT1, turn=0, scores=0, faces=0, winner=00.
- In WAIT1, req1 rising edge with rand1 held at 3 -> rng_run1 high exactly 32 cycles; face1=4, score1=4, roll_done single pulse, turn=1.
- In WAIT1, req2 pulses, then req1 and req2 rise together -> req2 ignored; only P1 rolls; score2 unchanged.
- rand1=7 forced, then rand2=6 -> face1=2, face2=1 (mod-6 mapping).
- TARGET_SCORE=10, P1 rolls faces 6,6 with P2 rolls 1 between -> after second P1 latch score1=12, end_of_game=1, winner=01; further req1/req2 ignored; start restarts with zeroed scores.
- Reset asserted mid-ROLL2 -> rng_run2=0 immediately, all outputs 0. With DICE_EXTRA_TURN_EN defined, P1 face 6 (score<target) -> turn stays 0 and WAIT1 is re-entered.
